// File: rtl/vedic_mac_pkg.sv
// Shared definitions for the Vedic multiply-accumulate stage.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package vedic_mac_pkg;

  localparam int OPND_W = 8;   // operand width
  localparam int PROD_W = 16;  // full product width of an 8x8 multiply

  // Control FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/multiplier_16bit_8by8.sv
// Combinational unsigned 8x8 Vedic (Urdhva Tiryagbhyam) multiplier, 16-bit product.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the product follows a/b continuously.
// Ports: a, b - 8-bit unsigned operands; prod - 16-bit product.
module multiplier_16bit_8by8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod
);

  // 2x2 leaf: vertical terms on the ends, crosswise sum in the middle.
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    logic       c;
    r[0]       = x[0] & y[0];
    {c, r[1]}  = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    {r[3], r[2]} = {1'b0, x[1] & y[1]} + {1'b0, c};
    return r;
  endfunction

  // 4x4 built from four 2x2 partial products.
  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, lh, hl, hh;
    ll = vm2(x[1:0], y[1:0]);
    lh = vm2(x[3:2], y[1:0]);
    hl = vm2(x[1:0], y[3:2]);
    hh = vm2(x[3:2], y[3:2]);
    return {4'b0, ll} + {2'b0, lh, 2'b0} + {2'b0, hl, 2'b0} + {hh, 4'b0};
  endfunction

  logic [7:0] p_ll, p_lh, p_hl, p_hh;

  always_comb begin
    p_ll = vm4(a[3:0], b[3:0]);
    p_lh = vm4(a[7:4], b[3:0]);
    p_hl = vm4(a[3:0], b[7:4]);
    p_hh = vm4(a[7:4], b[7:4]);
    prod = {8'b0, p_ll} + {4'b0, p_lh, 4'b0} + {4'b0, p_hl, 4'b0} + {p_hh, 8'b0};
  end

endmodule

// File: rtl/vedic_mac_acc.sv
// Accumulator register with sticky overflow and wrap/saturate add.
// Latency: 1 cycle from add_en to updated acc/overflow.
// Backpressure: none; clr and add_en are applied every cycle they are high.
// Ports: clr - zero acc and overflow; add_en/prod - add the product this edge;
//        acc - running sum; overflow - sticky carry-out flag.
// Build option: VEDIC_MAC_SATURATE_EN clamps the sum to all-ones on carry-out.
module vedic_mac_acc
  import vedic_mac_pkg::*;
#(
  parameter int ACC_W = 24   // must be >= PROD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc,
  output logic              overflow
);

  // One extra bit so the carry out of the top accumulator bit is visible.
  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (add_en) begin
      overflow <= overflow | sum[ACC_W];
`ifdef VEDIC_MAC_SATURATE_EN
      // Once clamped at all-ones any non-zero add carries again, so the
      // value stays pinned without a separate hold flag.
      acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc <= sum[ACC_W-1:0];
`endif
    end
  end

endmodule

// File: rtl/vedic_mac_8x8.sv
// Burst multiply-accumulate over a Vedic 8x8 multiplier: sums len products, returns one result.
// Latency: result valid 2 cycles after the last input transfer (1 cycle after start when len=0).
// Backpressure: in_ready only in RUN while pairs remain; result held in DONE until out_ready.
// Ports: start/len - burst request (IDLE only); in_valid/in_ready/a/b - operand stream;
//        out_valid/out_ready/acc_out/overflow - result handshake; busy - not IDLE.
// Build option: VEDIC_MAC_SATURATE_EN selects a saturating accumulator (default wraps).
module vedic_mac_8x8
  import vedic_mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  state_t             state;
  logic [LEN_W-1:0]   remain;
  logic [PROD_W-1:0]  mult_p;
  logic [PROD_W-1:0]  prod_q;
  logic               prod_v;
  logic               xfer;
  logic               clr;

  assign xfer = in_valid & in_ready;
  // Accumulator clears on the same edge that accepts a start.
  assign clr  = (state == IDLE) & start;

  multiplier_16bit_8by8 u_mult (
    .a    (a),
    .b    (b),
    .prod (mult_p)
  );

  // Control FSM, product pipe register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remain    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      prod_q    <= '0;
      prod_v    <= 1'b0;
    end else begin
      prod_v <= xfer;
      if (xfer) begin
        prod_q <= mult_p;
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              remain   <= len;
              in_ready <= 1'b1;
              state    <= RUN;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            remain <= remain - LEN_W'(1);
            // Last pair: stop accepting on the same edge so no extra transfer slips in.
            if (remain == LEN_W'(1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end

        // The final product sitting in prod_q is added during this cycle.
        DRAIN: begin
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  vedic_mac_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .add_en   (prod_v),
    .prod     (prod_q),
    .acc      (acc_out),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_vedic_mac_8x8.sv
// Directed bench for vedic_mac_8x8: a default-width DUT and a 16-bit-accumulator DUT
// share the same stimulus so wrap/saturate overflow is exercised alongside normal bursts.
module tb_vedic_mac_8x8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_ready;

  logic        in_ready, out_valid, overflow, busy;
  logic [23:0] acc_out;
  logic        in_ready16, out_valid16, overflow16, busy16;
  logic [15:0] acc_out16;

  int checks = 0;
  int errors = 0;

  vedic_mac_8x8 #(.ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow), .busy(busy)
  );

  vedic_mac_8x8 #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .out_valid(out_valid16), .out_ready(out_ready),
    .acc_out(acc_out16), .overflow(overflow16), .busy(busy16)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [7:0]      len;
    logic [7:0][7:0] a;
    logic [7:0][7:0] b;
    logic [15:0]     vpat;   // in_valid per offered cycle, bit 0 first
    logic [23:0]     exp;    // expected 24-bit result
    logic [15:0]     exp16;  // expected 16-bit result
    logic            ovf16;  // expected 16-bit overflow
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    int   idx;
    int   cyc;
    logic x;
    @(negedge clk);
    start = 1'b1;
    len   = v.len;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " in_ready after start"}, {31'b0, in_ready}, 1);
    chk({tag, " busy after start"}, {31'b0, busy}, 1);
    idx = 0;
    cyc = 0;
    while (idx < int'(v.len) && cyc < 16) begin
      in_valid = v.vpat[cyc];
      a        = v.a[idx];
      b        = v.b[idx];
      x        = in_valid & in_ready;
      @(negedge clk);
      if (x) idx++;
      cyc++;
    end
    chk({tag, " transfers"}, idx, {24'b0, v.len});
    // Keep offering data in DRAIN: it must not be taken.
    in_valid = 1'b1;
    chk({tag, " in_ready drain"}, {31'b0, in_ready}, 0);
    chk({tag, " out_valid drain"}, {31'b0, out_valid}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " out_valid"}, {31'b0, out_valid}, 1);
    chk({tag, " acc_out"}, {8'b0, acc_out}, {8'b0, v.exp});
    chk({tag, " overflow"}, {31'b0, overflow}, 0);
    chk({tag, " acc_out16"}, {16'b0, acc_out16}, {16'b0, v.exp16});
    chk({tag, " overflow16"}, {31'b0, overflow16}, {31'b0, v.ovf16});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after take"}, {31'b0, out_valid}, 0);
    chk({tag, " busy after take"}, {31'b0, busy}, 0);
  endtask

  initial begin
    vec_t r;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; len = '0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;

    // Vector table
    for (int i = 0; i < 5; i++) begin
      vecs[i] = '0;
      vecs[i].vpat = 16'hFFFF;
    end
    vecs[0].len = 3;
    vecs[0].a[0] = 3;   vecs[0].b[0] = 4;
    vecs[0].a[1] = 255; vecs[0].b[1] = 255;
    vecs[0].a[2] = 0;   vecs[0].b[2] = 9;
    vecs[0].exp = 65037; vecs[0].exp16 = 65037; vecs[0].ovf16 = 0;

    vecs[1].len = 4;
    vecs[1].vpat = 16'h0059;  // 1,0,0,1,1,0,1
    vecs[1].a[0] = 10;  vecs[1].b[0] = 20;
    vecs[1].a[1] = 1;   vecs[1].b[1] = 1;
    vecs[1].a[2] = 200; vecs[1].b[2] = 100;
    vecs[1].a[3] = 17;  vecs[1].b[3] = 3;
    vecs[1].exp = 20252; vecs[1].exp16 = 20252; vecs[1].ovf16 = 0;

    vecs[2].len = 2;
    vecs[2].a[0] = 128; vecs[2].b[0] = 2;
    vecs[2].a[1] = 15;  vecs[2].b[1] = 15;
    vecs[2].exp = 481; vecs[2].exp16 = 481; vecs[2].ovf16 = 0;

    vecs[3].len = 5;
    vecs[3].a[0] = 255; vecs[3].b[0] = 1;
    vecs[3].a[1] = 2;   vecs[3].b[1] = 128;
    vecs[3].a[2] = 16;  vecs[3].b[2] = 16;
    vecs[3].a[3] = 99;  vecs[3].b[3] = 99;
    vecs[3].a[4] = 255; vecs[3].b[4] = 255;
    vecs[3].exp = 75593; vecs[3].ovf16 = 1;

    vecs[4].len = 2;
    vecs[4].a[0] = 255; vecs[4].b[0] = 255;
    vecs[4].a[1] = 255; vecs[4].b[1] = 255;
    vecs[4].exp = 130050; vecs[4].ovf16 = 1;
`ifdef VEDIC_MAC_SATURATE_EN
    vecs[3].exp16 = 65535;
    vecs[4].exp16 = 65535;
`else
    vecs[3].exp16 = 10057;
    vecs[4].exp16 = 64514;
`endif

    // Reset state
    #12;
    chk("reset in_ready", {31'b0, in_ready}, 0);
    chk("reset out_valid", {31'b0, out_valid}, 0);
    chk("reset acc_out", {8'b0, acc_out}, 0);
    chk("reset overflow", {31'b0, overflow}, 0);
    chk("reset busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i], $sformatf("vec%0d", i));
    end

    // len=0: immediate result, held while out_ready stays low
    @(negedge clk);
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("len0 out_valid c%0d", k), {31'b0, out_valid}, 1);
      chk($sformatf("len0 acc_out c%0d", k), {8'b0, acc_out}, 0);
      chk($sformatf("len0 in_ready c%0d", k), {31'b0, in_ready}, 0);
      @(negedge clk);
    end
    chk("len0 overflow16 cleared", {31'b0, overflow16}, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("len0 out_valid after take", {31'b0, out_valid}, 0);

    // Mid-burst asynchronous reset after 2 of 5 transfers
    @(negedge clk);
    start = 1'b1; len = 8'd5;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a = 8'd9; b = 8'd9;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst acc before reset", {8'b0, acc_out}, 81);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", {31'b0, in_ready}, 0);
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst out_valid", {31'b0, out_valid}, 0);
    chk("midrst acc_out", {8'b0, acc_out}, 0);
    chk("midrst overflow", {31'b0, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = '0;
    r.vpat = 16'hFFFF; r.len = 1; r.a[0] = 7; r.b[0] = 6;
    r.exp = 42; r.exp16 = 42; r.ovf16 = 0;
    run_burst(r, "postrst");

    // start pulses in RUN and DONE are ignored
    @(negedge clk);
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b1; len = 8'd7; in_valid = 1'b1; a = 8'd5; b = 8'd5;
    @(negedge clk);
    start = 1'b0; a = 8'd6; b = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ign in_ready drain", {31'b0, in_ready}, 0);
    @(negedge clk);
    chk("ign out_valid", {31'b0, out_valid}, 1);
    chk("ign acc_out", {8'b0, acc_out}, 61);
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    chk("ign out_valid held", {31'b0, out_valid}, 1);
    chk("ign acc_out held", {8'b0, acc_out}, 61);
    chk("ign in_ready in done", {31'b0, in_ready}, 0);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk("ign out_valid after take", {31'b0, out_valid}, 0);
    chk("ign busy after take", {31'b0, busy}, 0);
    chk("ign acc_out after take", {8'b0, acc_out}, 61);
    @(negedge clk);
    chk("ign still idle", {31'b0, busy}, 0);
    chk("ign no run", {31'b0, in_ready}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vedic_mac_8x8.md
Name: vedic_mac_8x8

Overview:
Multiply-accumulate stage that consumes the 16-bit products of the combinational 8x8 Vedic multiplier. Accepts a programmed-length stream of unsigned 8-bit operand pairs over a valid/ready handshake. Registers each product, sums the products into a wide accumulator, and presents the final sum over a valid/ready output handshake. It sits directly downstream of multiplier_16bit_8by8 and instantiates it internally.

Parameters:
ACC_W, 24, accumulator and result width in bits; must be >= 16
LEN_W, 8, width of the burst-length field; maximum length is 2^LEN_W-1

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a burst; sampled only in IDLE
len  input  LEN_W  number of operand pairs in the burst; sampled together with start
in_valid  input  1  operand pair on a/b is valid
in_ready  output  1  block accepts a/b this cycle
a  input  8  unsigned multiplicand
b  input  8  unsigned multiplier
out_valid  output  1  acc_out and overflow are final
out_ready  input  1  consumer takes the result
acc_out  output  ACC_W  accumulated sum of products
overflow  output  1  sticky flag: the sum exceeded 2^ACC_W-1 during the burst
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; in_ready=0, out_valid=0, acc_out=0, overflow=0, busy=0; product pipe register invalid; counters=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0.
  - start=1 with len!=0: clear the accumulator and overflow, load remain=len, go to RUN.
  - start=1 with len=0: clear the accumulator and overflow, go directly to DONE (acc_out=0).
- RUN: in_ready=1 while remain>0. A transfer occurs on in_valid&&in_ready, which decrements remain.
  - On the transfer that takes remain from 1 to 0, go to DRAIN next cycle.
  - in_valid bubbles are allowed and do not change state.
- Datapath latency:
  - Product register prod_q<=a*b, and prod_v<=transfer, in the cycle of the transfer.
  - The accumulator adds prod_q in the following cycle when prod_v=1.
  - Back-to-back transfers sustain one product per cycle.
- DRAIN: one cycle. in_ready=0. The last product is added; go to DONE.
- DONE: out_valid=1. acc_out and overflow are held stable until out_valid&&out_ready; then go to IDLE and drop out_valid in the next cycle.
- start outside IDLE is ignored. start and out_ready in the same cycle in DONE: the burst completes, and start is not honoured until IDLE.
- Arithmetic: unsigned, zero-extend the 16-bit product to ACC_W+1 bits and add.
  - Bit ACC_W of the sum sets overflow (sticky until the next accepted start).
  - Without the optional feature, the accumulator wraps modulo 2^ACC_W.
- Mid-burst rst_n assertion aborts immediately to the reset values; no partial result is emitted.
- Max product 255*255=65025. With the defaults (ACC_W=24, LEN_W=8), a full burst of 255 maximal pairs sums to 16,581,375 < 2^24 and cannot overflow. Overflow is reachable only with a smaller ACC_W or a larger LEN_W.

Optional Feature:
VEDIC_MAC_SATURATE_EN:
- Defined: on any add whose carry out of bit ACC_W-1 is set, the accumulator clamps to 2^ACC_W-1 and stays clamped for the rest of the burst. overflow is still set.
- Undefined: the accumulator wraps; overflow still set.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package vedic_mac_pkg:
  - FSM state encoding constants: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - PROD_W=16 and OPND_W=8 constants.
- Combinational product: one instance of the existing multiplier_16bit_8by8. No new multiplier.
- One natural new sub-module: vedic_mac_acc. It holds the accumulator register, overflow flag and the saturate/wrap add, and is controlled by clr and add_en. The FSM and handshake stay in the top module.

Test Plan:
- Reset, then start with len=3 and pairs (3,4), (255,255), (0,9) back-to-back -> out_valid 2 cycles after the last transfer; acc_out=65037, overflow=0.
- start with len=0 -> out_valid the cycle after start; acc_out=0. Hold out_ready=0 for 5 cycles -> output stable, in_ready=0 throughout.
- len=4 with in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 transfers counted; in_ready drops after the 4th; sum equals the reference model.
- Build with ACC_W=16: two pairs (255,255),(255,255) -> overflow=1. acc_out=64514 without the macro; 65535 with VEDIC_MAC_SATURATE_EN.
- Assert rst_n low mid-RUN after 2 of 5 transfers -> all outputs 0 asynchronously. A new start with len=1, pair (7,6) -> acc_out=42, overflow=0.
- start pulsed while in RUN and DONE -> ignored. Result of the first burst is unchanged, and the next burst starts only after the out_valid&&out_ready transfer.
